// File: rtl/wb_initiator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_initiator_pkg
// Description : Shared types for the single-outstanding Wishbone initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_initiator_pkg;

    typedef enum logic [1:0] {
        WB_OK      = 2'b00,
        WB_ERR     = 2'b01,
        WB_TIMEOUT = 2'b10,
        WB_RETRY   = 2'b11
    } t_wb_status;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_STROBE = 3'd1,
        ST_WAIT   = 3'd2,
        ST_RETRY  = 3'd3,
        ST_RESP   = 3'd4
    } t_wb_state;

endpackage
`default_nettype wire

// File: rtl/wb_initiator_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_initiator_if
// Description : Wishbone B4 pipelined bus bundle between initiator and slave.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      wb_cyc_o;
    logic                      wb_stb_o;
    logic                      wb_we_o;
    logic [ADDR_WIDTH-1:0]     wb_adr_o;
    logic [DATA_WIDTH/8-1:0]   wb_sel_o;
    logic [DATA_WIDTH-1:0]     wb_dat_o;
    logic                      wb_ack_i;
    logic                      wb_err_i;
    logic                      wb_rty_i;
    logic                      wb_stall_i;
    logic [DATA_WIDTH-1:0]     wb_dat_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        input  wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
        output wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i, wb_dat_i
    );
endinterface
`default_nettype wire

// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : wb_initiator
// Description : Single-outstanding Wishbone B4 pipelined master with bounded
//               retry and cycle timeout; valid/ready request and response.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_initiator
    import wb_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255,
    parameter int MAX_RETRY  = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,

    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_we_i,
    input  logic [ADDR_WIDTH-1:0]   req_adr_i,
    input  logic [DATA_WIDTH/8-1:0] req_sel_i,
    input  logic [DATA_WIDTH-1:0]   req_dat_i,

    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_dat_o,
    output t_wb_status              rsp_status_o,

    wb_initiator_if.master          wb
);

    localparam int                  c_SEL_W        = DATA_WIDTH / 8;
    localparam int                  c_TIMER_W      = 16;
    localparam int                  c_RETRY_W      = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT_LAST = c_TIMER_W'(TIMEOUT - 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY    = c_RETRY_W'(MAX_RETRY);

    t_wb_state              r_state;
    logic                   r_req_ready;
    logic                   r_cyc;
    logic                   r_stb;
    logic                   r_we;
    logic [ADDR_WIDTH-1:0]  r_adr;
    logic [c_SEL_W-1:0]     r_sel;
    logic [DATA_WIDTH-1:0]  r_dat;
    logic                   r_rsp_valid;
    logic [DATA_WIDTH-1:0]  r_rsp_dat;
    t_wb_status             r_rsp_status;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_RETRY_W-1:0]   r_retry_cnt;

    t_wb_state              w_state_nxt;
    t_wb_status             w_status_nxt;
    logic [DATA_WIDTH-1:0]  w_rsp_dat_nxt;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [c_RETRY_W-1:0]   w_retry_nxt;
    logic                   w_accept;
    logic                   w_term_seen;

    // A termination only counts once the strobe has been taken (no stall)
    // or while waiting for the slave after it was taken.
    always_comb begin
        w_state_nxt   = r_state;
        w_status_nxt  = r_rsp_status;
        w_rsp_dat_nxt = r_rsp_dat;
        w_timer_nxt   = r_timer;
        w_retry_nxt   = r_retry_cnt;
        w_accept      = 1'b0;
        w_term_seen   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (req_valid_i && r_req_ready) begin
                    w_accept    = 1'b1;
                    w_timer_nxt = '0;
                    w_retry_nxt = '0;
                    w_state_nxt = ST_STROBE;
                end
            end

            ST_STROBE, ST_WAIT: begin
                w_term_seen = (wb.wb_ack_i || wb.wb_err_i || wb.wb_rty_i) &&
                              ((r_state == ST_WAIT) || !wb.wb_stall_i);
                if (r_timer != '1) begin
                    w_timer_nxt = r_timer + 1'b1;
                end

                if (w_term_seen) begin
                    if (wb.wb_err_i) begin
                        w_state_nxt   = ST_RESP;
                        w_status_nxt  = WB_ERR;
                        w_rsp_dat_nxt = '0;
                    end else if (wb.wb_rty_i) begin
                        if (r_retry_cnt < c_MAX_RETRY) begin
                            w_state_nxt = ST_RETRY;
                        end else begin
                            w_state_nxt   = ST_RESP;
                            w_status_nxt  = WB_RETRY;
                            w_rsp_dat_nxt = '0;
                        end
                    end else begin
                        w_state_nxt   = ST_RESP;
                        w_status_nxt  = WB_OK;
                        w_rsp_dat_nxt = r_we ? '0 : wb.wb_dat_i;
                    end
                end else if (r_timer == c_TIMEOUT_LAST) begin
                    w_state_nxt   = ST_RESP;
                    w_status_nxt  = WB_TIMEOUT;
                    w_rsp_dat_nxt = '0;
                end else if ((r_state == ST_STROBE) && !wb.wb_stall_i) begin
                    w_state_nxt = ST_WAIT;
                end
            end

            ST_RETRY: begin
                w_retry_nxt = r_retry_cnt + 1'b1;
                w_timer_nxt = '0;
                w_state_nxt = ST_STROBE;
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output flags are registered from the next state so no bus input
    // ever reaches an output combinationally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_sel        <= '0;
            r_dat        <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_dat    <= '0;
            r_rsp_status <= WB_OK;
            r_timer      <= '0;
            r_retry_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= (w_state_nxt == ST_IDLE);
            r_cyc        <= (w_state_nxt == ST_STROBE) || (w_state_nxt == ST_WAIT);
            r_stb        <= (w_state_nxt == ST_STROBE);
            r_rsp_valid  <= (w_state_nxt == ST_RESP);
            r_rsp_dat    <= w_rsp_dat_nxt;
            r_rsp_status <= w_status_nxt;
            r_timer      <= w_timer_nxt;
            r_retry_cnt  <= w_retry_nxt;
            if (w_accept) begin
                r_we  <= req_we_i;
                r_adr <= req_adr_i;
                r_sel <= req_sel_i;
                r_dat <= req_dat_i;
            end
        end
    end

    assign req_ready_o  = r_req_ready;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_dat_o    = r_rsp_dat;
    assign rsp_status_o = r_rsp_status;

    assign wb.wb_cyc_o  = r_cyc;
    assign wb.wb_stb_o  = r_stb;
    assign wb.wb_we_o   = r_we;
    assign wb.wb_adr_o  = r_adr;
    assign wb.wb_sel_o  = r_sel;
    assign wb.wb_dat_o  = r_dat;

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_initiator
// Description : Self-checking bench for wb_initiator with a scripted slave
//               and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_initiator;
    import wb_initiator_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;
    localparam int MR = 3;

    localparam int T_NONE   = 0;
    localparam int T_ACK    = 1;
    localparam int T_ERR    = 2;
    localparam int T_RTY    = 3;
    localparam int T_ACKERR = 4;
    localparam int T_ACKRTY = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_adr;
    logic [3:0]    req_sel;
    logic [DW-1:0] req_dat;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_dat;
    logic [1:0]    rsp_status;

    int checks   = 0;
    int failures = 0;

    // scripted slave configuration, set before each transfer
    int          sl_stall_cycles = 0;
    int          sl_wait_cycles  = 0;
    int          sl_term         = T_ACK;
    int          sl_rty_first    = 0;
    int          sl_attempt      = 0;
    bit          sl_junk         = 1'b0;
    int          sl_stb_seen     = 0;
    int          sl_wait_cnt     = 0;
    int          sl_cur          = T_NONE;
    bit          sl_in_att       = 1'b0;
    logic [31:0] sl_mem    [16];
    logic [31:0] model_mem [16];

    wb_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb ();

    wb_initiator #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO),
        .MAX_RETRY  (MR)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_adr_i    (req_adr),
        .req_sel_i    (req_sel),
        .req_dat_i    (req_dat),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_dat_o    (rsp_dat),
        .rsp_status_o (rsp_status),
        .wb           (wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_drive(input int code);
        wb.wb_ack_i = (code == T_ACK) || (code == T_ACKERR) || (code == T_ACKRTY);
        wb.wb_err_i = (code == T_ERR) || (code == T_ACKERR);
        wb.wb_rty_i = (code == T_RTY) || (code == T_ACKRTY);
    endtask

    // Slave: per attempt, stall s strobe cycles, take the strobe, terminate
    // w cycles after taking it. Only a plain ack commits a write.
    initial begin
        for (int i = 0; i < 16; i++) sl_mem[i] = '0;
        wb.wb_ack_i = 1'b0; wb.wb_err_i = 1'b0; wb.wb_rty_i = 1'b0;
        wb.wb_stall_i = 1'b0; wb.wb_dat_i = '0;
        forever begin
            @(negedge clk);
            begin
                bit fire;
                int idx;
                fire = 1'b0;
                idx  = int'(wb.wb_adr_o[5:2]);
                slave_drive(T_NONE);
                wb.wb_stall_i = 1'b0;
                if (!wb.wb_cyc_o) begin
                    sl_in_att   = 1'b0;
                    sl_stb_seen = 0;
                    sl_wait_cnt = 0;
                    wb.wb_dat_i = $urandom;
                end else begin
                    if (!sl_in_att) begin
                        sl_in_att = 1'b1;
                        sl_cur    = (sl_attempt < sl_rty_first) ? T_RTY : sl_term;
                        sl_attempt++;
                    end
                    wb.wb_dat_i = wb.wb_we_o ? $urandom : sl_mem[idx];
                    if (wb.wb_stb_o) begin
                        if (sl_stb_seen < sl_stall_cycles) begin
                            wb.wb_stall_i = 1'b1;
                            if (sl_junk) slave_drive(sl_cur);
                        end else begin
                            sl_wait_cnt = 0;
                            fire = (sl_wait_cycles == 0);
                        end
                        sl_stb_seen++;
                    end else begin
                        sl_wait_cnt++;
                        fire = (sl_wait_cnt == sl_wait_cycles);
                    end
                    if (fire) begin
                        slave_drive(sl_cur);
                        if (sl_cur == T_ACK && wb.wb_we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (wb.wb_sel_o[b]) sl_mem[idx][8*b +: 8] = wb.wb_dat_o[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Transaction-level prediction: status, cyc/stb cycle totals, attempts.
    task automatic model(input int s, input int w, input int t, input int k,
                         output logic [1:0] st, output int cyc_tot,
                         output int stb_tot, output int att);
        cyc_tot = 0; stb_tot = 0; att = 0; st = WB_OK;
        for (int a = 0; a <= MR; a++) begin
            int term;
            term = (a < k) ? T_RTY : t;
            att++;
            if (term == T_NONE || (s + 1 + w) > TO) begin
                cyc_tot += TO;
                stb_tot += ((s + 1) < TO) ? (s + 1) : TO;
                st = WB_TIMEOUT;
                return;
            end
            cyc_tot += s + 1 + w;
            stb_tot += s + 1;
            if (term == T_ERR || term == T_ACKERR) begin
                st = WB_ERR;
                return;
            end
            if (term == T_RTY || term == T_ACKRTY) begin
                if (a == MR) begin
                    st = WB_RETRY;
                    return;
                end
            end else begin
                st = WB_OK;
                return;
            end
        end
    endtask

    task automatic txn(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input int s, input int w, input int t,
                       input int k, input bit junk, input int hold, input string tag);
        logic [1:0]  e_st;
        logic [31:0] e_dat;
        logic [1:0]  st0;
        logic [31:0] d0;
        int e_cyc, e_stb, e_att;
        int n_cyc, n_stb, n_att, n_lat, guard;
        bit prev_cyc, bus_ok, hold_ok;

        model(s, w, t, k, e_st, e_cyc, e_stb, e_att);
        e_dat = (e_st == WB_OK && !we) ? model_mem[adr[5:2]] : 32'h0;

        sl_stall_cycles = s; sl_wait_cycles = w; sl_term = t;
        sl_rty_first = k; sl_junk = junk; sl_attempt = 0;

        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_req_ready"}, req_ready, 1);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_sel = sel; req_dat = dat;
        @(negedge clk);
        req_valid = 1'b0;

        n_cyc = 0; n_stb = 0; n_att = 0; n_lat = 0; prev_cyc = 1'b0; bus_ok = 1'b1;
        while (!rsp_valid && n_lat < 200) begin
            if (wb.wb_cyc_o) begin
                n_cyc++;
                if (wb.wb_adr_o !== adr || wb.wb_we_o !== we ||
                    wb.wb_sel_o !== sel || wb.wb_dat_o !== dat) bus_ok = 1'b0;
            end
            if (wb.wb_stb_o) n_stb++;
            if (wb.wb_cyc_o && !prev_cyc) n_att++;
            prev_cyc = wb.wb_cyc_o;
            n_lat++;
            @(negedge clk);
        end

        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_status"},    rsp_status, e_st);
        check({tag, "_rsp_dat"},   rsp_dat, e_dat);
        check({tag, "_cyc_cycles"}, n_cyc, e_cyc);
        check({tag, "_stb_cycles"}, n_stb, e_stb);
        check({tag, "_attempts"},  n_att, e_att);
        check({tag, "_latency"},   n_lat, e_cyc + e_att - 1);
        check({tag, "_bus_held"},  bus_ok, 1);
        check({tag, "_cyc_at_rsp"}, {wb.wb_cyc_o, wb.wb_stb_o}, 0);
        check({tag, "_busy"},      req_ready, 0);

        st0 = rsp_status; d0 = rsp_dat; hold_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!rsp_valid || req_ready || rsp_status !== st0 || rsp_dat !== d0 || wb.wb_cyc_o)
                hold_ok = 1'b0;
        end
        check({tag, "_rsp_hold"}, hold_ok, 1);

        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_done"},  rsp_valid, 0);
        check({tag, "_ready_back"}, req_ready, 1);

        if (e_st == WB_OK && we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) model_mem[adr[5:2]][8*b +: 8] = dat[8*b +: 8];
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0;
        req_sel = '0; req_dat = '0; rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_cyc_stb_we", {wb.wb_cyc_o, wb.wb_stb_o, wb.wb_we_o}, 0);
        check("rst_adr", wb.wb_adr_o, 0);
        check("rst_sel_dat", {wb.wb_sel_o, wb.wb_dat_o}, 0);
        check("rst_rsp", {rsp_valid, rsp_status, rsp_dat}, 0);

        rst_n = 1'b1;
        #1 check("rel_ready_before_edge", req_ready, 0);
        @(negedge clk);
        check("rel_ready_after_edge", req_ready, 1);

        // register-bank slave with stall = ~ack, ack one cycle after stb
        txn(1'b1, 32'h0, 4'hF, 32'hCAFEF00D, 1, 0, T_ACK, 0, 1'b0, 0, "wr_cafe");
        txn(1'b0, 32'h0, 4'hF, 32'h0, 0, 0, T_ACK, 0, 1'b0, 0, "rd_cafe");
        txn(1'b1, 32'h4, 4'hF, 32'h12345678, 0, 0, T_ACK, 0, 1'b0, 0, "wr_1234");
        txn(1'b0, 32'h4, 4'hF, 32'h0, 3, 2, T_ACK, 0, 1'b0, 0, "rd_stall");
        txn(1'b0, 32'h4, 4'hF, 32'h0, 0, 0, T_RTY, 0, 1'b0, 0, "rty_always");
        txn(1'b0, 32'h8, 4'hF, 32'h0, 0, 0, T_NONE, 0, 1'b0, 0, "timeout");
        txn(1'b0, 32'h4, 4'hF, 32'h0, 0, 15, T_ACK, 0, 1'b0, 0, "ack_last_cycle");
        txn(1'b0, 32'h4, 4'hF, 32'h0, 0, 16, T_ACK, 0, 1'b0, 0, "ack_too_late");
        txn(1'b0, 32'h4, 4'hF, 32'h0, 20, 0, T_ACK, 0, 1'b0, 0, "stall_timeout");
        txn(1'b0, 32'h4, 4'hF, 32'h0, 0, 1, T_ACKERR, 0, 1'b0, 5, "ack_err_hold");
        txn(1'b0, 32'h4, 4'hF, 32'h0, 1, 1, T_ACKRTY, 0, 1'b0, 0, "ack_rty");
        txn(1'b0, 32'h4, 4'hF, 32'h0, 1, 0, T_ACK, 2, 1'b0, 1, "rty2_then_ack");
        txn(1'b1, 32'hC, 4'h5, 32'hA1B2C3D4, 2, 1, T_ACK, 0, 1'b1, 0, "junk_wr_sel");
        txn(1'b0, 32'hC, 4'hF, 32'h0, 2, 1, T_ERR, 0, 1'b1, 0, "junk_err");
        txn(1'b0, 32'hC, 4'hF, 32'h0, 0, 0, T_ACK, 0, 1'b0, 0, "rd_sel");

        for (int n = 0; n < 40; n++) begin
            bit          r_we;
            logic [31:0] r_adr;
            int          r_s, r_t, r_pick;
            r_we   = 1'($urandom_range(0, 1));
            r_adr  = 32'($urandom_range(0, 15)) << 2;
            r_s    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20))
                                                 : int'($urandom_range(0, 4));
            r_pick = int'($urandom_range(0, 9));
            r_t    = (r_pick <= 4) ? T_ACK : (r_pick == 5) ? T_ERR : (r_pick == 6) ? T_RTY :
                     (r_pick == 7) ? T_ACKERR : (r_pick == 8) ? T_ACKRTY : T_NONE;
            txn(r_we, r_adr, 4'($urandom_range(1, 15)), $urandom, r_s,
                int'($urandom_range(0, 4)), r_t, int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), $sformatf("rand%0d", n));
        end

        // reset pulse while the initiator waits on an unresponsive slave
        sl_stall_cycles = 0; sl_wait_cycles = 1000; sl_term = T_ACK;
        sl_rty_first = 0; sl_junk = 1'b0; sl_attempt = 0;
        check("mid_rst_ready", req_ready, 1);
        req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h8; req_sel = 4'hF; req_dat = '0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_in_wait", {wb.wb_cyc_o, wb.wb_stb_o}, 2'b10);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_cyc_stb_drop", {wb.wb_cyc_o, wb.wb_stb_o}, 0);
        check("mid_rst_no_rsp", {rsp_valid, req_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready_after", req_ready, 1);
        check("mid_rst_quiet", {rsp_valid, wb.wb_cyc_o}, 0);

        txn(1'b0, 32'h0, 4'hF, 32'h0, 0, 0, T_ACK, 0, 1'b0, 0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_initiator.md
# wb_initiator

Single-outstanding Wishbone B4 pipelined master that turns a simple valid/ready request into one bus cycle and returns a response with status. It sits between an internal controller (sequencer, debug bridge, CPU shim) and any generated register-bank slave. It handles `wb_stall_i`, ack/err/rty termination, bounded retry and a cycle timeout.

## Interface
- `ADDR_WIDTH`, default 32: width of `req_adr_i` / `wb_adr_o` (byte address).
- `DATA_WIDTH`, default 32: data width. `DATA_WIDTH/8` select bits.
- `TIMEOUT`, default 255: maximum cycles with `wb_cyc_o` high before abort. Legal range 1..65535.
- `MAX_RETRY`, default 3: number of re-issues allowed after `wb_rty_i`. 0 means the first rty is reported.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i` in 1: clock.
- `rst_n_i` in 1: asynchronous active-low reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when high together with `req_valid_i`.
- `req_we_i` in 1: 1 = write.
- `req_adr_i` in ADDR_WIDTH: address.
- `req_sel_i` in DATA_WIDTH/8: byte select.
- `req_dat_i` in DATA_WIDTH: write data.
- `rsp_valid_o` out 1: response present.
- `rsp_ready_i` in 1: response consumed.
- `rsp_dat_o` out DATA_WIDTH: read data. 0 for writes and for failed reads.
- `rsp_status_o` out 2: `t_wb_status`.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone control.
- `wb_adr_o` out ADDR_WIDTH, `wb_sel_o` out DATA_WIDTH/8, `wb_dat_o` out DATA_WIDTH: Wishbone address, select and write data.
- `wb_ack_i`, `wb_err_i`, `wb_rty_i`, `wb_stall_i` in 1: Wishbone termination and stall.
- `wb_dat_i` in DATA_WIDTH: Wishbone read data.

## Operation
- FSM states:
  - IDLE: `req_ready_o`=1. On accept, latch we/adr/sel/dat, clear the timer and retry count, go to STROBE.
  - STROBE: cyc=1, stb=1. When `wb_stall_i`=0, the strobe is accepted.
    - If a termination is also present in that cycle, go to DONE.
    - Otherwise go to WAIT.
    - Terminations seen while `wb_stall_i`=1 are ignored.
  - WAIT: cyc=1, stb=0. Any termination goes to DONE.
  - RETRY: cyc=0 for exactly one cycle, increment the retry count, then return to STROBE. The timer is cleared on re-entry to STROBE.
  - RESP: `rsp_valid_o`=1, outputs held stable. When `rsp_ready_i`=1, go to IDLE.
- DONE is the termination decision, not a state. It resolves as follows:
  - `wb_err_i` → RESP with ERR.
  - Otherwise `wb_rty_i`: if retry count < MAX_RETRY → RETRY, else → RESP with RETRY.
  - Otherwise `wb_ack_i` → RESP with OK. Capture `wb_dat_i` when the transfer is a read.
- Termination priority: err > rty > ack.
- Timer counts every cycle with cyc=1 and saturates. If it reaches TIMEOUT without a termination, go to RESP with TIMEOUT and drop cyc/stb.
- Bus outputs are registered and change only on state transitions. `wb_adr_o`/`wb_sel_o`/`wb_we_o`/`wb_dat_o` are held for the whole cycle, including across retries.
- Reset values: every output is 0, including `req_ready_o`. `req_ready_o` is a registered flag that becomes 1 on the first clock after reset release. The state is IDLE.
- Reset mid-operation: cyc/stb drop asynchronously, the pending request is discarded and no response is produced.

## Timing
- Request accepted at edge N → `wb_cyc_o`/`wb_stb_o` high from N+1.
- Zero-wait slave (stall=0, ack in the first stb cycle): cyc/stb high for 1 cycle, `rsp_valid_o` high from N+2.
- Termination observed at edge M → `wb_cyc_o`=0 and `rsp_valid_o`=1 after M. There is no cycle with cyc=1 after a termination.
- After the response handshake at edge R: `req_ready_o`=1 after R, so the next accept is possible at R+1. Maximum throughput is one transfer per 3 cycles.
- Timeout: cyc is high for exactly TIMEOUT cycles, then cyc=0 and `rsp_valid_o`=1.
- `rsp_valid_o` is held while `rsp_ready_i`=0. There is no combinational path from Wishbone inputs to any output.

## Structure
- Package `wb_initiator_pkg` contains:
  - `t_wb_status` enum: OK=2'b00, ERR=2'b01, TIMEOUT=2'b10, RETRY=2'b11.
  - FSM state enum.
- Timer, retry counter and FSM live in one module. A sub-module is not warranted.

## Test plan
- Write 0xCAFEF00D to 0x0, against a register-bank slave with stall = ~ack and ack one cycle after stb → cyc high 2 cycles, rsp OK, readback of 0x0 returns 0xCAFEF00D.
- Read with stall held 3 cycles, then ack 2 cycles after acceptance with dat=0x12345678 → stb high 4 cycles, then stb=0 and cyc=1 for 2 cycles, rsp OK, dat 0x12345678.
- Slave asserts rty every time, MAX_RETRY=3 → 4 strobes, each separated by one cyc=0 cycle, then rsp RETRY with dat 0.
- Slave never responds, TIMEOUT=16 → cyc high exactly 16 cycles, then rsp TIMEOUT.
- ack and err asserted together → rsp ERR. Hold `rsp_ready_i`=0 for 5 cycles → rsp held, `req_ready_o`=0 throughout.
- `rst_n_i` pulsed low while in WAIT → cyc/stb=0 immediately, no rsp_valid, `req_ready_o`=1 on the first clock after release.
